// File: rtl/serial_tc_pkg.sv
// -----------------------------------------------------------------------------
// serial_tc_pkg
// Shared definitions for the multi-lane serial two's-complement block:
//   - MODE_PASS / MODE_NEG : values of the 'mode' input
//   - state_e              : framing FSM states
//   - cnt_width()          : width of the bit counter for a W-bit word
// -----------------------------------------------------------------------------
package serial_tc_pkg;

    localparam logic MODE_PASS = 1'b0;
    localparam logic MODE_NEG  = 1'b1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    // Bit counter width, clog2(W); never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_tc_lane.sv
// -----------------------------------------------------------------------------
// serial_tc_lane
// One lane of the serial two's-complement block. Each enabled cycle it
// processes one LSB-first input bit, registers the result bit and shifts it
// into a word register. On the last bit it publishes the parallel word and
// the negate-overflow flag, both of which hold until the next last bit.
//
// Ports:
//   t_clk  in   clock, rising edge
//   r      in   synchronous active-high reset
//   en     in   a bit is accepted this cycle
//   clr    in   the accepted bit is bit 0 of a new word (clears seen_one)
//   neg    in   mode for the accepted bit (MODE_NEG negates)
//   last   in   the accepted bit is the MSB
//   i_bit  in   serial input bit
//   y      out  registered serial result bit
//   word   out  parallel result, valid from the cycle 'last' was registered
//   ovf    out  negate overflow of the last completed word
// -----------------------------------------------------------------------------
module serial_tc_lane
    import serial_tc_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         t_clk,
    input  logic         r,
    input  logic         en,
    input  logic         clr,
    input  logic         neg,
    input  logic         last,
    input  logic         i_bit,
    output logic         y,
    output logic [W-1:0] word,
    output logic         ovf
);

    logic         seen_one_q, seen_one_d;
    logic         y_q,        y_d;
    logic [W-1:0] shift_q,    shift_d;
    logic [W-1:0] word_q,     word_d;
    logic         ovf_q,      ovf_d;

    // seen_one as it applies to this bit: a new word starts with no 1 seen.
    logic seen_eff;
    logic y_next;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        seen_one_d = seen_one_q;
        y_d        = y_q;
        shift_d    = shift_q;
        word_d     = word_q;
        ovf_d      = ovf_q;

        seen_eff = seen_one_q & ~clr;
        // Two's complement LSB-first: copy up to and including the first 1,
        // invert every bit after it.
        y_next   = (neg == MODE_NEG && seen_eff) ? ~i_bit : i_bit;

        if (en) begin
            seen_one_d = seen_eff | i_bit;
            y_d        = y_next;
            shift_d    = {y_next, shift_q[W-1:1]};
            if (last) begin
                word_d = {y_next, shift_q[W-1:1]};
                // MSB set with no earlier 1 means the input was -2^(W-1).
                ovf_d  = (neg == MODE_NEG) & i_bit & ~seen_eff;
            end
        end
    end

    always_ff @(posedge t_clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every flop samples the values from before this edge.
        if (r) begin
            seen_one_q <= 1'b0;
            y_q        <= 1'b0;
            shift_q    <= '0;
            word_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            seen_one_q <= seen_one_d;
            y_q        <= y_d;
            shift_q    <= shift_d;
            word_q     <= word_d;
            ovf_q      <= ovf_d;
        end
    end

    assign y    = y_q;
    assign word = word_q;
    assign ovf  = ovf_q;

endmodule

// File: rtl/serial_twos_comp_lanes.sv
// -----------------------------------------------------------------------------
// serial_twos_comp_lanes
// N parallel lanes of bit-serial, LSB-first pass / two's-complement negate
// sharing one word framing. Results appear one cycle after each accepted bit.
//
// Ports:
//   t_clk      in   clock, rising edge
//   r          in   synchronous active-high reset
//   in_valid   in   input bit strobe (all lanes)
//   sof        in   marks bit 0 of a word when in_valid=1
//   mode       in   0 pass, 1 negate; sampled on an accepted sof
//   i[N]       in   serial input bit per lane
//   y[N]       out  serial result bit per lane
//   y_valid    out  y is meaningful
//   y_eof      out  y is the MSB of a word
//   word[N*W]  out  parallel results, lane k at [k*W +: W]
//   word_valid out  one-cycle pulse, word complete
//   ovf[N]     out  per-lane negate overflow, held with word
//   frame_err  out  one-cycle pulse on a framing violation
// -----------------------------------------------------------------------------
module serial_twos_comp_lanes
    import serial_tc_pkg::*;
#(
    parameter int W = 8,
    parameter int N = 1
) (
    input  logic           t_clk,
    input  logic           r,
    input  logic           in_valid,
    input  logic           sof,
    input  logic           mode,
    input  logic [N-1:0]   i,
    output logic [N-1:0]   y,
    output logic           y_valid,
    output logic           y_eof,
    output logic [N*W-1:0] word,
    output logic           word_valid,
    output logic [N-1:0]   ovf,
    output logic           frame_err
);

    localparam int             CW       = cnt_width(W);
    localparam logic [CW-1:0]  LAST_IDX = CW'(W - 1);

    state_e        state_q,      state_d;
    logic [CW-1:0] cnt_q,        cnt_d;
    logic          mode_q,       mode_d;
    logic          y_valid_q,    y_valid_d;
    logic          y_eof_q,      y_eof_d;
    logic          word_valid_q, word_valid_d;
    logic          frame_err_q,  frame_err_d;

    logic          start;     // accepted sof
    logic          proc;      // a bit is processed this cycle
    logic          last;      // the processed bit is the MSB
    logic [CW-1:0] bit_idx;   // index of the processed bit
    logic          bit_mode;  // mode applied to the processed bit

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mode_d       = mode_q;
        frame_err_d  = 1'b0;

        start    = in_valid & sof;
        proc     = in_valid & (sof | (state_q == ACTIVE));
        bit_idx  = start ? '0 : cnt_q;
        bit_mode = start ? mode : mode_q;
        last     = proc & (bit_idx == LAST_IDX);

        // An sof inside a word aborts it; a non-sof bit outside a word is
        // dropped. Either way the violation is flagged.
        if (in_valid) begin
            frame_err_d = sof ? (state_q == ACTIVE) : (state_q == IDLE);
        end

        if (start) begin
            mode_d = mode;
        end

        if (proc) begin
            if (last) begin
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                cnt_d   = bit_idx + CW'(1);
                state_d = ACTIVE;
            end
        end

        y_valid_d    = proc;
        y_eof_d      = last;
        word_valid_d = last;
    end

    always_ff @(posedge t_clk) begin
        if (r) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mode_q       <= MODE_PASS;
            y_valid_q    <= 1'b0;
            y_eof_q      <= 1'b0;
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            y_valid_q    <= y_valid_d;
            y_eof_q      <= y_eof_d;
            word_valid_q <= word_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_lane
        serial_tc_lane #(
            .W (W)
        ) u_lane (
            .t_clk (t_clk),
            .r     (r),
            .en    (proc),
            .clr   (start),
            .neg   (bit_mode),
            .last  (last),
            .i_bit (i[k]),
            .y     (y[k]),
            .word  (word[k*W +: W]),
            .ovf   (ovf[k])
        );
    end

    assign y_valid    = y_valid_q;
    assign y_eof      = y_eof_q;
    assign word_valid = word_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_serial_twos_comp_lanes.sv
// -----------------------------------------------------------------------------
// tb_serial_twos_comp_lanes
// Scoreboard bench: every driven cycle pushes the outputs expected after that
// clock edge; a monitor pops one entry per cycle on the falling edge.
// Expected words come from arithmetic negation, not from a bit-level model.
// -----------------------------------------------------------------------------
module tb_serial_twos_comp_lanes;

    localparam int W = 8;
    localparam int N = 2;

    logic           t_clk;
    logic           r;
    logic           in_valid;
    logic           sof;
    logic           mode;
    logic [N-1:0]   i;
    logic [N-1:0]   y;
    logic           y_valid;
    logic           y_eof;
    logic [N*W-1:0] word;
    logic           word_valid;
    logic [N-1:0]   ovf;
    logic           frame_err;

    serial_twos_comp_lanes #(
        .W (W),
        .N (N)
    ) dut (
        .t_clk      (t_clk),
        .r          (r),
        .in_valid   (in_valid),
        .sof        (sof),
        .mode       (mode),
        .i          (i),
        .y          (y),
        .y_valid    (y_valid),
        .y_eof      (y_eof),
        .word       (word),
        .word_valid (word_valid),
        .ovf        (ovf),
        .frame_err  (frame_err)
    );

    initial t_clk = 1'b0;
    always #5 t_clk = ~t_clk;

    typedef struct packed {
        logic           yv;
        logic [N-1:0]   y;
        logic           eof;
        logic           fe;
        logic           wv;
        logic [N*W-1:0] word;
        logic [N-1:0]   ovf;
    } exp_t;

    exp_t           exp_q[$];
    logic [N*W-1:0] hold_word = '0;
    logic [N-1:0]   hold_ovf  = '0;
    int             n_checks  = 0;
    int             n_errors  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [N*W-1:0] ref_result(input logic m, input logic [N*W-1:0] xs);
        logic [N*W-1:0] res;
        logic [W-1:0]   lane;
        logic [W-1:0]   zero;
        zero = '0;
        for (int l = 0; l < N; l++) begin
            lane = xs[l*W +: W];
            res[l*W +: W] = m ? (zero - lane) : lane;
        end
        return res;
    endfunction

    function automatic logic [N-1:0] ref_ovf(input logic m, input logic [N*W-1:0] xs);
        logic [N-1:0] ov;
        logic [W-1:0] min_neg;
        min_neg = '0;
        min_neg[W-1] = 1'b1;
        for (int l = 0; l < N; l++) begin
            ov[l] = m && (xs[l*W +: W] == min_neg);
        end
        return ov;
    endfunction

    // Drive one cycle and queue the outputs expected after its clock edge.
    task automatic cycle(input logic rr, input logic v, input logic s, input logic m,
                         input logic [N-1:0] b, input logic eyv, input logic [N-1:0] ey,
                         input logic eeof, input logic efe, input logic ewv,
                         input logic [N*W-1:0] ew, input logic [N-1:0] eov);
        exp_t e;
        r        = rr;
        in_valid = v;
        sof      = s;
        mode     = m;
        i        = b;
        if (rr) begin
            hold_word = '0;
            hold_ovf  = '0;
            e = '0;
        end else begin
            if (ewv) begin
                hold_word = ew;
                hold_ovf  = eov;
            end
            e.yv   = eyv;
            e.y    = ey;
            e.eof  = eeof;
            e.fe   = efe;
            e.wv   = ewv;
            e.word = hold_word;
            e.ovf  = hold_ovf;
        end
        exp_q.push_back(e);
        @(posedge t_clk);
        #1;
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 1'b0, 1'($urandom), 1'($urandom), N'($urandom),
              1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // Send the first nbits bits of one word on all lanes; optionally insert
    // gap_len idle cycles after bit gap_at; fe_first marks an aborting sof.
    task automatic send_word(input logic m, input logic [N*W-1:0] xs, input int nbits,
                             input int gap_at, input int gap_len, input logic fe_first);
        logic [N*W-1:0] res;
        logic [N-1:0]   ov;
        logic [N-1:0]   b;
        logic [N-1:0]   yb;
        res = ref_result(m, xs);
        ov  = ref_ovf(m, xs);
        for (int k = 0; k < nbits; k++) begin
            for (int l = 0; l < N; l++) begin
                b[l]  = xs[l*W + k];
                yb[l] = res[l*W + k];
            end
            // Mode is driven inverted off-sof: only the latched value may matter.
            cycle(1'b0, 1'b1, (k == 0), (k == 0) ? m : ~m, b,
                  1'b1, yb, (k == W-1), (k == 0) && fe_first, (k == W-1), res, ov);
            if (k == gap_at) begin
                for (int g = 0; g < gap_len; g++) idle_cycle();
            end
        end
    endtask

    // Monitor: one expected entry per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge t_clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("y_valid",    32'(y_valid),    32'(e.yv));
                if (e.yv) check("y", 32'(y), 32'(e.y));
                check("y_eof",      32'(y_eof),      32'(e.eof));
                check("frame_err",  32'(frame_err),  32'(e.fe));
                check("word_valid", 32'(word_valid), 32'(e.wv));
                check("word",       32'(word),       32'(e.word));
                check("ovf",        32'(ovf),        32'(e.ovf));
            end
        end
    end

    initial begin
        // Reset for 3 cycles with random inputs: everything reads 0.
        for (int c = 0; c < 3; c++) begin
            cycle(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), N'($urandom),
                  1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
        end
        idle_cycle();

        // Negate: lane0=0x06 -> 0xFA, lane1=0x01 -> 0xFF.
        send_word(1'b1, {8'h01, 8'h06}, W, -1, 0, 1'b0);
        idle_cycle();

        // Overflow and zero, then pass back-to-back with no bubble.
        send_word(1'b1, {8'h00, 8'h80}, W, -1, 0, 1'b0);
        send_word(1'b0, {8'h5A, 8'h5A}, W, -1, 0, 1'b0);
        idle_cycle();

        // in_valid dropped for 3 cycles after bit 3.
        send_word(1'b1, {8'h06, 8'h06}, W, 3, 3, 1'b0);
        idle_cycle();

        // Abort at bit 4 with a new sof, then a full 0x03 negate word.
        send_word(1'b1, {8'h06, 8'h06}, 4, -1, 0, 1'b0);
        send_word(1'b1, {8'h03, 8'h03}, W, -1, 0, 1'b1);
        idle_cycle();

        // Unframed bits while IDLE: one frame_err per bit, no y_valid.
        for (int c = 0; c < 2; c++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'($urandom), N'($urandom),
                  1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0);
        end
        idle_cycle();

        // Reset presented with bit 5: partial word discarded.
        send_word(1'b1, {8'h37, 8'hC4}, 5, -1, 0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
        idle_cycle();
        send_word(1'b1, {8'h37, 8'hC4}, W, -1, 0, 1'b0);

        // Random words, random mode, back-to-back.
        for (int n = 0; n < 6; n++) begin
            send_word(1'($urandom), (N*W)'($urandom), W, -1, 0, 1'b0);
        end
        idle_cycle();

        @(negedge t_clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_twos_comp_lanes.md
Name: serial_twos_comp_lanes

Overview:
- Parametrised, multi-lane successor to the single-bit serial two's-complement inverter.
- Each lane takes a bit-serial, LSB-first word and outputs either the word unchanged or its two's complement, one bit per accepted input bit.
- Adds word framing, a valid qualifier, overflow detection and a deserialised parallel result per lane.
- Sits between serial sample sources and word-oriented consumers in the datapath.

Parameters:
- W, 8, word length in bits (W >= 2).
- N, 1, number of independent lanes sharing one framing.

Ports:
- t_clk  in  1  clock; all logic on rising edge.
- r  in  1  reset, synchronous, active-high.
- in_valid  in  1  input bit strobe, common to all lanes.
- sof  in  1  start of frame: qualifies the LSB of a word when in_valid=1.
- mode  in  1  0 = pass, 1 = negate; sampled only on an accepted sof.
- i  in  N  serial input bit per lane.
- y  out  N  serial result bit per lane.
- y_valid  out  1  y is meaningful this cycle.
- y_eof  out  1  y carries the MSB of a word.
- word  out  N*W  parallel result; lane k occupies bits [k*W+W-1 : k*W].
- word_valid  out  1  one-cycle pulse; word is complete.
- ovf  out  N  per-lane negate overflow; valid with word_valid.
- frame_err  out  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (r=1 at a clock edge): state=IDLE, bit counter=0, mode register=0, seen_one[N]=0. All outputs are 0, including word. Reset wins over every other input in the same cycle, and reset mid-word discards the partial word with no output pulses.
- FSM states: IDLE, ACTIVE. A bit counter cnt runs 0..W-1.
- IDLE:
  - in_valid & sof: latch mode, process bit 0, cnt<=1, go to ACTIVE.
  - in_valid & ~sof: bit ignored, frame_err pulses next cycle, y_valid stays 0.
- ACTIVE:
  - in_valid & ~sof: process bit cnt, cnt<=cnt+1.
  - When the bit with cnt==W-1 is processed: y_eof=1, word_valid=1, go to IDLE.
  - in_valid & sof with cnt!=0: frame_err pulses, the partial word is discarded (no word_valid), and the bit is treated as bit 0 of a new word (mode re-latched, cnt<=1).
  - in_valid=0: hold all state; y_valid=0 next cycle.
- Per-lane bit processing (the processed bit is i at the accepted cycle):
  - pass mode: y_next = i.
  - negate mode: y_next = seen_one ? ~i : i; then seen_one <= seen_one | i.
  - seen_one clears at every accepted sof.
- Latency: y, y_valid and y_eof are registered and appear exactly 1 cycle after the accepted input bit.
- word is built LSB-first from y_next. word_valid pulses in the same cycle as the MSB's y/y_eof, and word holds its value until the next word_valid.
- Overflow: in negate mode, ovf[k] = 1 when the MSB input is 1 and seen_one was 0 before it (input = -2^(W-1), whose negation is unrepresentable; the result equals the input). ovf is always 0 in pass mode. ovf holds its value alongside word.
- Back-to-back words: an sof in the cycle directly after the MSB is accepted, with no bubble required.
- Zero input in negate mode gives zero output and ovf=0.

Decomposition:
- Package serial_tc_pkg holds:
  - the mode constants MODE_PASS=1'b0 and MODE_NEG=1'b1;
  - the FSM state typedef (IDLE, ACTIVE);
  - a function computing the counter width, clog2(W).
- Sub-module serial_tc_lane: one lane. It holds seen_one, the y register, the word shift register and ovf, with enable, clear and last-bit inputs from the top.
- The top holds the FSM, cnt, the mode register, the framing outputs, and a generate loop over N lanes.

Test Plan:
- Reset: hold r=1 for 3 cycles with random inputs -> y, y_valid, y_eof, word, word_valid, ovf and frame_err all 0.
- W=8, N=2, negate: lane0=0x06, lane1=0x01 -> lane0 y=0,1,0,1,1,1,1,1 and word=0xFA; lane1 word=0xFF; word_valid one cycle, 1 cycle after the MSB is accepted; ovf=00.
- Negate with lane0=0x80, lane1=0x00 -> words 0x80 and 0x00, ovf=01; then pass mode with 0x5A on both lanes back-to-back -> 0x5A on both lanes, ovf=00, no bubble between words.
- in_valid dropped for 3 cycles after bit 3 of 0x06 in negate mode -> y_valid low for those 3 cycles, final word still 0xFA.
- sof reasserted at bit 4, then a full 0x03 word in negate mode -> frame_err one pulse, no word_valid for the aborted word, next word=0xFD.
- Bits with in_valid=1 and sof=0 while IDLE -> frame_err pulse, y_valid=0. r=1 at bit 5 of a word -> no word_valid; the next framed word is correct.
